ifetch_seq: RTL and testbench

Sequential instruction-fetch stage for the Minisys core. Holds the program counter, fetches each instruction over a req/ack instruction-memory port, and presents it to decode/execute for one or more cycles. It closes the loop with the execute stage by consuming the branch target, zero flag and jr register value to select the next PC. Each instruction occupies one FETCH/EXEC pair.

---
 rtl/ifetch_seq_pkg.sv | 23 ++
 rtl/ifetch_seq_if.sv | 33 +++
 rtl/ifetch_next_pc.sv | 41 ++++
 rtl/ifetch_seq.sv | 151 +++++++++++++++
 tb/tb_ifetch_seq.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/ifetch_seq_pkg.sv
// ifetch_seq_pkg
// Shared definitions for the Minisys instruction-fetch stage:
//   - fetch_state_e : sequencer state encoding
//   - JTGT_*        : jump-target field position inside the instruction word
//   - *_DEF         : default parameter values for ifetch_seq
package ifetch_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_ERROR = 2'd3
  } fetch_state_e;

  localparam int JTGT_MSB = 25;
  localparam int JTGT_LSB = 0;
  localparam int JTGT_W   = JTGT_MSB - JTGT_LSB + 1;

  localparam logic [31:0] RESET_PC_DEF    = 32'h0000_0000;
  localparam int          IMEM_AW_DEF     = 14;
  localparam int          ACK_TIMEOUT_DEF = 255;

endpackage

// File: rtl/ifetch_seq_if.sv
// ifetch_seq_if
// Instruction-memory req/ack port.
//   imem_req   : fetch request (fetch stage -> memory)
//   imem_addr  : word address (fetch stage -> memory)
//   imem_rdata : instruction word (memory -> fetch stage), valid with imem_ack
//   imem_ack   : fetch completes this cycle (memory -> fetch stage)
// Modports: master = fetch stage, slave = memory.
interface ifetch_seq_if
  import ifetch_seq_pkg::*;
#(
  parameter int IMEM_AW = IMEM_AW_DEF
) ();

  logic               imem_req;
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        imem_rdata;
  logic               imem_ack;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_ack
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_ack
  );

endinterface

// File: rtl/ifetch_next_pc.sv
// ifetch_next_pc
// Combinational next-PC selection from the execute-stage feedback.
// Priority: jr > j/jal > taken branch > sequential.
//   pc_plus_4   : PC+4 of the instruction in EXEC
//   jtgt        : instruction jump-target field (word address)
//   add_result  : branch target, word address (low 30 bits used)
//   read_data_1 : rs value, jr target (byte address, may be misaligned)
//   zero, branch, nbranch, jmp, jal, jrn : decoded control / ALU flag
//   next_pc     : selected byte address (low bits unmasked)
module ifetch_next_pc
  import ifetch_seq_pkg::*;
(
  input  logic [31:0]       pc_plus_4,
  input  logic [JTGT_W-1:0] jtgt,
  input  logic [29:0]       add_result,
  input  logic [31:0]       read_data_1,
  input  logic              zero,
  input  logic              branch,
  input  logic              nbranch,
  input  logic              jmp,
  input  logic              jal,
  input  logic              jrn,
  output logic [31:0]       next_pc
);

  logic br_taken;

  assign br_taken = (branch & zero) | (nbranch & ~zero);

  always_comb begin
    next_pc = pc_plus_4;
    if (jrn) begin
      next_pc = read_data_1;
    end else if (jmp | jal) begin
      next_pc = {pc_plus_4[31:28], jtgt, 2'b00};
    end else if (br_taken) begin
      next_pc = {add_result, 2'b00};
    end
  end

endmodule

// File: rtl/ifetch_seq.sv
// ifetch_seq
// Sequential instruction-fetch stage: holds the PC, fetches one instruction
// per FETCH/EXEC pair over the imem req/ack port and selects the next PC
// from the execute-stage feedback.
//
// Ports:
//   clock, reset (async, active-low)
//   imem          : instruction-memory port (ifetch_seq_if.master)
//   Instruction   : captured instruction word
//   PC_plus_4     : PC+4 of the current instruction
//   inst_valid    : high in EXEC
//   exec_stall    : downstream busy, holds EXEC
//   Add_Result, Zero, Read_data_1, Branch, nBranch, Jmp, Jal, Jrn : next-PC inputs
//   fetch_err     : sticky fault (ack timeout or misaligned jump)
//
// Build option: IFETCH_MISALIGN_CHK_EN
//   defined   -> a misaligned next PC in EXEC moves to ERROR, PC not updated
//   undefined -> next PC low two bits are forced to zero
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | one cycle after reset, no request
// ST_FETCH | imem_req high, waiting for imem_ack (timeout counting)
// ST_EXEC  | Instruction valid to decode/execute, held while exec_stall
// ST_ERROR | fault, request and valid low, left only by reset
module ifetch_seq
  import ifetch_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = RESET_PC_DEF,
  parameter int          IMEM_AW     = IMEM_AW_DEF,
  parameter int          ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic                clock,
  input  logic                reset,
  ifetch_seq_if.master        imem,
  output logic [31:0]         Instruction,
  output logic [31:0]         PC_plus_4,
  output logic                inst_valid,
  input  logic                exec_stall,
  input  logic [31:0]         Add_Result,
  input  logic                Zero,
  input  logic [31:0]         Read_data_1,
  input  logic                Branch,
  input  logic                nBranch,
  input  logic                Jmp,
  input  logic                Jal,
  input  logic                Jrn,
  output logic                fetch_err
);

  localparam int            TW       = $clog2(ACK_TIMEOUT + 1);
  // Down-counter loaded on FETCH entry; reaching zero without an ack in the
  // same cycle means ACK_TIMEOUT FETCH cycles have gone unanswered.
  localparam logic [TW-1:0] TMO_LOAD = TW'(ACK_TIMEOUT - 1);

  fetch_state_e  state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   instr_q, instr_d;
  logic [TW-1:0] tmo_q, tmo_d;

  logic [31:0]   pc_plus_4;
  logic [31:0]   raw_next_pc;
  logic          misalign;

  assign pc_plus_4 = pc_q + 32'd4;

  ifetch_next_pc u_next_pc (
    .pc_plus_4   (pc_plus_4),
    .jtgt        (instr_q[JTGT_MSB:JTGT_LSB]),
    .add_result  (Add_Result[29:0]),
    .read_data_1 (Read_data_1),
    .zero        (Zero),
    .branch      (Branch),
    .nbranch     (nBranch),
    .jmp         (Jmp),
    .jal         (Jal),
    .jrn         (Jrn),
    .next_pc     (raw_next_pc)
  );

`ifdef IFETCH_MISALIGN_CHK_EN
  assign misalign = |raw_next_pc[1:0];
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    tmo_d   = tmo_q;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
        tmo_d   = TMO_LOAD;
      end
      ST_FETCH: begin
        if (imem.imem_ack) begin
          instr_d = imem.imem_rdata;
          state_d = ST_EXEC;
        end else if (tmo_q == '0) begin
          state_d = ST_ERROR;
        end else begin
          tmo_d = tmo_q - TW'(1);
        end
      end
      ST_EXEC: begin
        if (!exec_stall) begin
          if (misalign) begin
            state_d = ST_ERROR;
          end else begin
            // Only jr can produce low bits; without the check they are dropped.
            pc_d    = raw_next_pc & ~32'h3;
            state_d = ST_FETCH;
            tmo_d   = TMO_LOAD;
          end
        end
      end
      ST_ERROR: begin
        state_d = ST_ERROR;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
      tmo_q   <= TMO_LOAD;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      tmo_q   <= tmo_d;
    end
  end

  // All outputs decode registered state only; the async reset drops imem_req
  // immediately, so an ack arriving afterwards meets IDLE and is ignored.
  assign imem.imem_req  = (state_q == ST_FETCH);
  assign imem.imem_addr = pc_q[IMEM_AW+1:2];
  assign inst_valid     = (state_q == ST_EXEC);
  assign fetch_err      = (state_q == ST_ERROR);
  assign Instruction    = instr_q;
  assign PC_plus_4      = pc_plus_4;

endmodule

// File: tb/tb_ifetch_seq.sv
module tb_ifetch_seq;
  import ifetch_seq_pkg::*;

  localparam int AW  = 14;
  localparam int TMO = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        exec_stall = 1'b0;
  logic        Zero = 1'b0, Branch = 1'b0, nBranch = 1'b0;
  logic        Jmp = 1'b0, Jal = 1'b0, Jrn = 1'b0;
  logic        ack_drv = 1'b0;
  logic [31:0] Add_Result = 32'h0, Read_data_1 = 32'h0;
  logic [31:0] Instruction, PC_plus_4;
  logic        inst_valid, fetch_err;

  logic [31:0] mem [0:63];
  logic [31:0] model_pc;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clock = ~clock;

  ifetch_seq_if #(.IMEM_AW(AW)) imem_bus ();
  assign imem_bus.imem_ack   = ack_drv;
  assign imem_bus.imem_rdata = mem[imem_bus.imem_addr[5:0]];

  ifetch_seq #(.RESET_PC(32'h0), .IMEM_AW(AW), .ACK_TIMEOUT(TMO)) dut (
    .clock       (clock),
    .reset       (reset),
    .imem        (imem_bus),
    .Instruction (Instruction),
    .PC_plus_4   (PC_plus_4),
    .inst_valid  (inst_valid),
    .exec_stall  (exec_stall),
    .Add_Result  (Add_Result),
    .Zero        (Zero),
    .Read_data_1 (Read_data_1),
    .Branch      (Branch),
    .nBranch     (nBranch),
    .Jmp         (Jmp),
    .Jal         (Jal),
    .Jrn         (Jrn),
    .fetch_err   (fetch_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Next PC straight from the architectural rule, before alignment handling.
  function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [31:0] ins,
                                           input bit br, input bit nbr, input bit jmp,
                                           input bit jal, input bit jrn, input bit z,
                                           input logic [31:0] ar, input logic [31:0] rd1);
    logic [31:0] p4;
    p4 = pc + 32'd4;
    if (jrn) return rd1;
    if (jmp || jal) return {p4[31:28], ins[25:0], 2'b00};
    if ((br && z) || (nbr && !z)) return {ar[29:0], 2'b00};
    return p4;
  endfunction

  task automatic check_fetch(input string tag);
    check({tag, "_req"}, 32'(imem_bus.imem_req), 32'd1);
    check({tag, "_addr"}, 32'(imem_bus.imem_addr), 32'(model_pc[AW+1:2]));
    check({tag, "_valid"}, 32'(inst_valid), 32'd0);
    check({tag, "_err"}, 32'(fetch_err), 32'd0);
  endtask

  task automatic expect_error(input int n);
    for (int i = 0; i < n; i++) begin
      ack_drv = 1'($urandom_range(0, 1));
      check("err_flag", 32'(fetch_err), 32'd1);
      check("err_req", 32'(imem_bus.imem_req), 32'd0);
      check("err_valid", 32'(inst_valid), 32'd0);
      tick();
    end
  endtask

  // Entered between edges; the request must drop as soon as reset asserts.
  task automatic do_reset();
    #2;
    reset = 1'b0;
    ack_drv = 1'b1;
    #1;
    check("rst_req", 32'(imem_bus.imem_req), 32'd0);
    check("rst_valid", 32'(inst_valid), 32'd0);
    check("rst_err", 32'(fetch_err), 32'd0);
    check("rst_instr", Instruction, 32'h0);
    check("rst_pc4", PC_plus_4, 32'h4);
    tick();
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("idle_req", 32'(imem_bus.imem_req), 32'd0);
    tick();
    model_pc = 32'h0;
    check("first_fetch_instr", Instruction, 32'h0);
    check_fetch("first_fetch");
  endtask

  task automatic rand_ctl();
    Branch      = 1'($urandom_range(0, 1));
    nBranch     = 1'($urandom_range(0, 1));
    Jmp         = 1'($urandom_range(0, 1));
    Jal         = 1'($urandom_range(0, 1));
    Jrn         = 1'($urandom_range(0, 1));
    Zero        = 1'($urandom_range(0, 1));
    Add_Result  = $urandom;
    Read_data_1 = $urandom;
  endtask

  // Called at #1 after the edge that entered FETCH.
  task automatic run_instr(input int waits, input int stalls,
                           input bit br, input bit nbr, input bit jmp, input bit jal,
                           input bit jrn, input bit z,
                           input logic [31:0] ar, input logic [31:0] rd1,
                           output bit faulted);
    logic [31:0] exp_ins;
    logic [31:0] tgt;
    faulted = 1'b0;
    exp_ins = mem[model_pc[7:2]];
    for (int i = 0; i < waits; i++) begin
      ack_drv = 1'b0;
      check_fetch("fetch_wait");
      tick();
    end
    ack_drv = 1'b1;
    check_fetch("fetch_ack");
    tick();
    for (int s = 0; s <= stalls; s++) begin
      ack_drv = 1'($urandom_range(0, 1));
      if (s < stalls) begin
        exec_stall = 1'b1;
        rand_ctl();
      end else begin
        exec_stall = 1'b0;
        Branch = br; nBranch = nbr; Jmp = jmp; Jal = jal; Jrn = jrn; Zero = z;
        Add_Result = ar; Read_data_1 = rd1;
      end
      check("exec_valid", 32'(inst_valid), 32'd1);
      check("exec_req", 32'(imem_bus.imem_req), 32'd0);
      check("exec_instr", Instruction, exp_ins);
      check("exec_pc4", PC_plus_4, model_pc + 32'd4);
      check("exec_err", 32'(fetch_err), 32'd0);
      tick();
    end
    exec_stall = 1'b0;
    ack_drv = 1'b0;
    tgt = ref_next(model_pc, exp_ins, br, nbr, jmp, jal, jrn, z, ar, rd1);
`ifdef IFETCH_MISALIGN_CHK_EN
    if (tgt[1:0] != 2'b00) begin
      faulted = 1'b1;
      return;
    end
`endif
    model_pc = {tgt[31:2], 2'b00};
  endtask

  task automatic plain(input int waits, input int stalls);
    bit f;
    run_instr(waits, stalls, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, f);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit f;
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    mem[2] = {6'h03, 26'h20};
    model_pc = 32'h0;

    do_reset();
    plain(0, 0);
    plain(0, 0);
    plain(0, 0);

    run_instr(0, 0, 1, 0, 0, 0, 0, 1, 32'h10, 32'h0, f);
    run_instr(0, 0, 1, 0, 0, 0, 0, 0, 32'h10, 32'h0, f);
    run_instr(0, 0, 0, 1, 0, 0, 0, 0, 32'h4, 32'h0, f);
    run_instr(0, 0, 0, 1, 0, 0, 0, 1, 32'h4, 32'h0, f);
    run_instr(0, 0, 0, 0, 1, 0, 1, 0, 32'h0, 32'h40, f);
    plain(3, 2);

    do_reset();
    plain(0, 0);
    plain(0, 0);
    run_instr(0, 0, 0, 0, 0, 1, 0, 0, 32'h0, 32'h0, f);
    plain(0, 0);

    run_instr(1, 1, 0, 0, 0, 0, 1, 0, 32'h0, 32'hFFFF_FFFC, f);
    plain(0, 0);
    plain(0, 0);

    run_instr(0, 0, 0, 0, 0, 0, 1, 0, 32'h0, 32'h42, f);
    if (f) begin
      expect_error(4);
      do_reset();
    end else begin
      plain(0, 0);
    end

    for (int i = 0; i < TMO; i++) begin
      ack_drv = 1'b0;
      check_fetch("tmo_fetch");
      tick();
    end
    expect_error(6);
    do_reset();

    for (int n = 0; n < 200; n++) begin
      run_instr($urandom_range(0, TMO - 1), $urandom_range(0, 2),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                $urandom, $urandom & ~32'h3, f);
      if (n == 100) do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
